alu_result_framer: RTL
======================

ALU_RESULT_FRAMER -- requirements
Module: alu_result_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of 16-bit result entries buffered; legal values 2 or 4.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_out  input  16  result word from ALU stage.
REQ-005 SHALL have port alu_valid  input  1  result qualifier; one push per cycle it is high.
REQ-006 SHALL have port tx_busy  input  1  UART TX busy; a byte is accepted in a cycle with tx_valid=1 and tx_busy=0.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of overflow flag.
REQ-008 SHALL have port tx_data  output  8  byte offered to UART TX.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid; registered.
REQ-010 SHALL have port pend_count  output  3  number of stored entries, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a result was dropped.
REQ-012 SHALL have port busy  output  1  high when pend_count!=0 or FSM not IDLE.

Function
REQ-013 SHALL push alu_out into a circular FIFO on each rising edge with alu_valid=1 and FIFO not full; write pointer wraps DEPTH-1 -> 0.
REQ-014 SHALL, on alu_valid=1 with FIFO full and no pop in the same cycle, drop the word, leave FIFO unchanged and set overflow on that edge.
REQ-015 SHALL, on simultaneous push and pop with FIFO full, accept the push; pend_count unchanged.
REQ-016 SHALL implement FSM states IDLE, SEND_LO, GAP, SEND_HI, GAP_END.
REQ-017 IDLE -> SEND_LO when pend_count!=0; tx_data=head[7:0], tx_valid=1 from next cycle.
REQ-018 SEND_LO: hold tx_valid=1 and tx_data stable until accept cycle (tx_busy=0); then -> GAP.
REQ-019 GAP: tx_valid=0 for exactly one cycle; -> SEND_HI with tx_data=head[15:8].
REQ-020 SEND_HI: hold until accept; on accept pop head (read pointer wraps) and -> GAP_END.
REQ-021 GAP_END: tx_valid=0 one cycle; -> SEND_LO if pend_count!=0 after pop, else IDLE.
REQ-022 Byte order SHALL be LSB first, then MSB; every result produces exactly two accepted bytes.
REQ-023 Latency: alu_valid at edge N into empty idle block SHALL give tx_valid=1 with LSB after edge N+2.
REQ-024 pend_count SHALL reflect push/pop of the current edge; entry stays counted until its MSB is accepted.
REQ-025 clr_ovf=1 SHALL clear overflow; if a drop occurs in the same cycle, set wins.
REQ-026 tx_busy high in SEND_LO/SEND_HI SHALL only stall; no timeout, no byte skipped.
REQ-027 tx_valid SHALL never be high in IDLE, GAP or GAP_END.

Reset
REQ-028 SHALL, on rst low, asynchronously force FSM=IDLE, pointers=0, pend_count=0, tx_valid=0, tx_data=0x00, overflow=0, busy=0.
REQ-029 SHALL discard buffered entries and any partially sent result on reset mid-transfer; no byte emitted after rst release until a new push.
REQ-030 SHALL ignore alu_valid while rst is low.

Verification
REQ-031 Single result: alu_out=0x1234 pulse, tx_busy=0 -> bytes 0x34 then 0x12, one idle cycle between, pend_count 1->0, busy low after GAP_END.
REQ-032 Stall: push 0xABCD, tx_busy=1 for 10 cycles -> tx_valid held with 0xCD stable 10 cycles, then 0xCD, 0xAB accepted once each.
REQ-033 Overflow: DEPTH=2, tx_busy=1, push 0x0001,0x0002,0x0003 -> overflow=1, pend_count=2; release -> 01,00,02,00 only.
REQ-034 Full push+pop: FIFO full, alu_valid=1 on MSB accept edge with 0x5555 -> no overflow, pend_count stays 2, 0x55,0x55 sent last.
REQ-035 Reset mid-transfer: rst low during SEND_HI of 0xBEEF -> tx_valid=0 immediately, no 0xBE after release, pend_count=0.
REQ-036 Clear race: clr_ovf=1 on same edge as a drop -> overflow remains 1; clr_ovf next cycle -> 0.

Source files
------------

// File: rtl/alu_result_framer.sv
// ALU result framer: buffers 16-bit ALU results in a small circular FIFO and
// serialises each one to a UART TX as two bytes, LSB first. A one-cycle gap
// separates consecutive bytes. Results that arrive while the FIFO is full are
// dropped and flagged on a sticky overflow bit.
//
// state   | meaning
// IDLE    | nothing to send; waiting for a buffered entry
// SEND_LO | offering head[7:0]; first cycle after IDLE is a setup cycle
// GAP     | one dead cycle between LSB and MSB
// SEND_HI | offering head[15:8]; entry is popped when this byte is accepted
// GAP_END | one dead cycle after the MSB; decide whether to continue
module alu_result_framer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_out,
    input  logic        alu_valid,
    input  logic        tx_busy,
    input  logic        clr_ovf,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic [2:0]  pend_count,
    output logic        overflow,
    output logic        busy
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEND_LO,
        GAP,
        SEND_HI,
        GAP_END
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   head;
    logic          full, accept, push, pop, drop;
    logic          tx_valid_nxt;
    logic [7:0]    tx_data_nxt;

    assign head   = mem[rd_ptr];
    assign full   = (pend_count == FULL_CNT);
    assign accept = tx_valid & ~tx_busy;
    // The head leaves the FIFO only once its MSB has been taken by the UART.
    assign pop    = (state == SEND_HI) & accept;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push   = alu_valid & (~full | pop);
    assign drop   = alu_valid & full & ~pop;
    assign busy   = (pend_count != 3'd0) || (state != IDLE);

    // Next-state and next-output decode for the byte serialiser.
    always_comb begin
        state_nxt    = state;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        case (state)
            IDLE: begin
                tx_valid_nxt = 1'b0;
                if (pend_count != 3'd0) begin
                    state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                if (accept) begin
                    state_nxt    = GAP;
                    tx_valid_nxt = 1'b0;
                end else if (!tx_valid) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = head[7:0];
                end
            end
            GAP: begin
                state_nxt    = SEND_HI;
                tx_valid_nxt = 1'b1;
                tx_data_nxt  = head[15:8];
            end
            SEND_HI: begin
                if (accept) begin
                    state_nxt    = GAP_END;
                    tx_valid_nxt = 1'b0;
                end
            end
            GAP_END: begin
                // The head pointer has already advanced, so head is the next entry.
                if (pend_count != 3'd0) begin
                    state_nxt    = SEND_LO;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = head[7:0];
                end else begin
                    state_nxt    = IDLE;
                    tx_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                tx_valid_nxt = 1'b0;
            end
        endcase
    end

    // Serialiser state and registered TX outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_count <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            pend_count <= pend_count + 3'(push) - 3'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= alu_out;
        end
    end

endmodule
